// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port 16-bit on-chip RAM
// with 1-cycle read latency, plus a clear engine that zero-fills every word.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int BE_W   = 2,
    parameter int DEPTH  = 15360
) (
    input  logic              clk,
    input  logic              reset_n,
    // master 0 (CPU data)
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    // master 1 (logger / DMA)
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    // clear engine
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    // RAM side
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic              prio_reg, prio_next;
    logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
    logic              pend_valid_reg, pend_valid_next;
    logic              pend_sel_reg, pend_sel_next;
    logic              pend_oor_reg, pend_oor_next;
    logic              clear_done_reg, clear_done_next;

    // per-master views so the grant mux can index by master number
    logic [1:0]        req;
    logic [1:0]        rd_vec;
    logic [1:0]        wr_vec;
    logic [ADDR_W-1:0] addr_arr [2];
    logic [BE_W-1:0]   be_arr   [2];
    logic [DATA_W-1:0] wd_arr   [2];

    logic              gnt_valid;
    logic              gnt_idx;
    logic              gnt_in_range;

    logic [1:0]        wait_vec;
    logic [1:0]        rdv_vec;
    logic [DATA_W-1:0] rdata_arr [2];

    assign rd_vec      = {m1_read, m0_read};
    assign wr_vec      = {m1_write, m0_write};
    assign req         = rd_vec | wr_vec;
    assign addr_arr[0] = m0_address;
    assign addr_arr[1] = m1_address;
    assign be_arr[0]   = m0_byteenable;
    assign be_arr[1]   = m1_byteenable;
    assign wd_arr[0]   = m0_writedata;
    assign wd_arr[1]   = m1_writedata;

    always_comb begin
        state_next      = state_reg;
        prio_next       = prio_reg;
        clr_cnt_next    = clr_cnt_reg;
        pend_valid_next = 1'b0;
        pend_sel_next   = pend_sel_reg;
        pend_oor_next   = 1'b0;
        clear_done_next = 1'b0;
        gnt_valid       = 1'b0;
        gnt_idx         = 1'b0;
        gnt_in_range    = 1'b0;
        mem_address     = '0;
        mem_byteenable  = '0;
        mem_chipselect  = 1'b0;
        mem_write       = 1'b0;
        mem_writedata   = '0;

        case (state_reg)
            RUN: begin
                if (clear_req) begin
                    state_next = CLEAR;
                end else if (req != 2'b00) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = (req == 2'b11) ? prio_reg : req[1];
                end
            end
            CLEAR: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_byteenable = '1;
                mem_address    = clr_cnt_reg;
                if (clr_cnt_reg == LAST_ADDR) begin
                    clr_cnt_next    = '0;
                    state_next      = RUN;
                    clear_done_next = 1'b1;
                end else begin
                    clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
                end
            end
            default: state_next = RUN;
        endcase

        // the handshake is combinational, so hold it off while reset is asserted
        if (!reset_n) begin
            gnt_valid = 1'b0;
        end

        if (gnt_valid) begin
            gnt_in_range   = {1'b0, addr_arr[gnt_idx]} < DEPTH_EXT;
            mem_address    = addr_arr[gnt_idx];
            mem_byteenable = be_arr[gnt_idx];
            mem_writedata  = wd_arr[gnt_idx];
            mem_chipselect = gnt_in_range;
            mem_write      = wr_vec[gnt_idx];
            prio_next      = ~gnt_idx;
            // read+write together is a write: no data phase follows
            if (rd_vec[gnt_idx] && !wr_vec[gnt_idx]) begin
                pend_valid_next = 1'b1;
                pend_sel_next   = gnt_idx;
                pend_oor_next   = ~gnt_in_range;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= RUN;
            prio_reg       <= 1'b0;
            clr_cnt_reg    <= '0;
            pend_valid_reg <= 1'b0;
            pend_sel_reg   <= 1'b0;
            pend_oor_reg   <= 1'b0;
            clear_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            prio_reg       <= prio_next;
            clr_cnt_reg    <= clr_cnt_next;
            pend_valid_reg <= pend_valid_next;
            pend_sel_reg   <= pend_sel_next;
            pend_oor_reg   <= pend_oor_next;
            clear_done_reg <= clear_done_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            assign wait_vec[gi]  = ~(gnt_valid && (gnt_idx == 1'(gi)));
            assign rdv_vec[gi]   = pend_valid_reg && (pend_sel_reg == 1'(gi));
            // out-of-range reads return zero rather than whatever the RAM drives
            assign rdata_arr[gi] = (rdv_vec[gi] && !pend_oor_reg) ? mem_readdata : '0;
        end
    endgenerate

    assign m0_waitrequest   = wait_vec[0];
    assign m1_waitrequest   = wait_vec[1];
    assign m0_readdatavalid = rdv_vec[0];
    assign m1_readdatavalid = rdv_vec[1];
    assign m0_readdata      = rdata_arr[0];
    assign m1_readdata      = rdata_arr[1];
    assign clear_busy       = (state_reg == CLEAR);
    assign clear_done       = clear_done_reg;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter: a vector table for single-cycle
// arbitration behaviour plus hand sequences for streaming, clear and reset.
module tb_onchip_mem_arbiter;

    localparam int DEPTH = 15360;

    logic        clk;
    logic        reset_n;
    logic [13:0] m0_address, m1_address;
    logic [1:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        clear_req, clear_busy, clear_done;
    logic [13:0] mem_address;
    logic [1:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [15:0] mem_writedata, mem_readdata;

    int checks = 0;
    int errors = 0;

    onchip_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: full 14-bit space so a wrongly enabled out-of-range write is visible
    logic [15:0] ram [0:16383];
    logic        bd_we = 1'b0;
    logic [13:0] bd_addr = '0;
    logic [15:0] bd_data = '0;
    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_chipselect && mem_write) begin
            if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
            if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
        end
        mem_readdata <= ram[mem_address];
    end

    typedef struct packed {
        logic r0, w0; logic [13:0] a0; logic [1:0] b0; logic [15:0] d0;
        logic r1, w1; logic [13:0] a1; logic [1:0] b1; logic [15:0] d1;
        logic ew0, ew1, ecs, ewe; logic [13:0] eaddr;
        logic ev0; logic [15:0] erd0;
        logic ev1; logic [15:0] erd1;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mkv(input int r0, input int w0, input int a0, input int b0, input int d0,
                                 input int r1, input int w1, input int a1, input int b1, input int d1,
                                 input int ew0, input int ew1, input int ecs, input int ewe, input int eaddr,
                                 input int ev0, input int erd0, input int ev1, input int erd1);
        vec_t v;
        v.r0 = r0[0]; v.w0 = w0[0]; v.a0 = a0[13:0]; v.b0 = b0[1:0]; v.d0 = d0[15:0];
        v.r1 = r1[0]; v.w1 = w1[0]; v.a1 = a1[13:0]; v.b1 = b1[1:0]; v.d1 = d1[15:0];
        v.ew0 = ew0[0]; v.ew1 = ew1[0]; v.ecs = ecs[0]; v.ewe = ewe[0]; v.eaddr = eaddr[13:0];
        v.ev0 = ev0[0]; v.erd0 = erd0[15:0]; v.ev1 = ev1[0]; v.erd1 = erd1[15:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = 2'b11; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = 2'b11; m1_writedata = '0;
        clear_req = 0;
    endtask

    task automatic preload(input logic [13:0] a, input logic [15:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    initial begin
        int stall, wi, ri, rcount, m0_rdv_seen;
        logic [13:0] last_clr;
        logic found;

        idle_inputs();
        reset_n = 1'b0;
        preload(14'h0010, 16'hBEEF);
        preload(14'd5, 16'hFFFF);
        preload(14'd15360, 16'h0F0F);
        preload(14'h3FFF, 16'hDEAD);
        preload(14'd0, 16'h1111);
        preload(14'd7000, 16'h7777);
        preload(14'd15359, 16'h3333);

        // reset values, with a live request to show the handshake is held off
        @(negedge clk);
        m0_read = 1'b1; m1_write = 1'b1;
        #1;
        $display("reset: w0=%b w1=%b cs=%b busy=%b", m0_waitrequest, m1_waitrequest, mem_chipselect, clear_busy);
        chk("rst_w0", 32'(m0_waitrequest), 1);
        chk("rst_w1", 32'(m1_waitrequest), 1);
        chk("rst_cs", 32'(mem_chipselect), 0);
        chk("rst_we", 32'(mem_write), 0);
        chk("rst_rdv", {30'b0, m1_readdatavalid, m0_readdatavalid}, 0);
        chk("rst_clr", {30'b0, clear_busy, clear_done}, 0);
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;

        //            r0 w0 a0       b0 d0        r1 w1 a1      b1 d1       ew0 ew1 cs we addr      ev0 erd0     ev1 erd1
        vt[0]  = mkv(1, 0, 'h10,    3, 0,        0, 0, 0,      3, 0,       0, 1, 1, 0, 'h10,       0, 0,        0, 0);
        vt[1]  = mkv(0, 0, 0,       3, 0,        0, 0, 0,      3, 0,       1, 1, 0, 0, 0,          1, 'hBEEF,   0, 0);
        vt[2]  = mkv(0, 0, 0,       3, 0,        0, 1, 5,      2, 'h1234,  1, 0, 1, 1, 5,          0, 0,        0, 0);
        vt[3]  = mkv(0, 0, 0,       3, 0,        1, 0, 5,      3, 0,       1, 0, 1, 0, 5,          0, 0,        0, 0);
        vt[4]  = mkv(0, 0, 0,       3, 0,        0, 0, 0,      3, 0,       1, 1, 0, 0, 0,          0, 0,        1, 'h12FF);
        vt[5]  = mkv(0, 1, 'h20,    3, 'hAAAA,   1, 0, 'h10,   3, 0,       0, 1, 1, 1, 'h20,       0, 0,        0, 0);
        vt[6]  = mkv(0, 1, 'h21,    3, 'hBBBB,   1, 0, 'h10,   3, 0,       1, 0, 1, 0, 'h10,       0, 0,        0, 0);
        vt[7]  = mkv(0, 1, 'h21,    3, 'hBBBB,   1, 0, 'h20,   3, 0,       0, 1, 1, 1, 'h21,       0, 0,        1, 'hBEEF);
        vt[8]  = mkv(0, 0, 0,       3, 0,        1, 0, 'h20,   3, 0,       1, 0, 1, 0, 'h20,       0, 0,        0, 0);
        vt[9]  = mkv(0, 0, 0,       3, 0,        1, 0, 'h21,   3, 0,       1, 0, 1, 0, 'h21,       0, 0,        1, 'hAAAA);
        vt[10] = mkv(0, 1, 15360,   3, 'h9999,   0, 0, 0,      3, 0,       0, 1, 0, 1, 15360,      0, 0,        1, 'hBBBB);
        vt[11] = mkv(1, 0, 'h3FFF,  3, 0,        0, 0, 0,      3, 0,       0, 1, 0, 0, 'h3FFF,     0, 0,        0, 0);
        vt[12] = mkv(1, 1, 'h10,    3, 'h4321,   0, 0, 0,      3, 0,       0, 1, 1, 1, 'h10,       1, 0,        0, 0);
        vt[13] = mkv(0, 0, 0,       3, 0,        0, 0, 0,      3, 0,       1, 1, 0, 0, 0,          0, 0,        0, 0);
        vt[14] = mkv(1, 0, 'h10,    3, 0,        0, 0, 0,      3, 0,       0, 1, 1, 0, 'h10,       0, 0,        0, 0);
        vt[15] = mkv(0, 0, 0,       3, 0,        0, 0, 0,      3, 0,       1, 1, 0, 0, 0,          1, 'h4321,   0, 0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            m0_read = vt[i].r0; m0_write = vt[i].w0; m0_address = vt[i].a0;
            m0_byteenable = vt[i].b0; m0_writedata = vt[i].d0;
            m1_read = vt[i].r1; m1_write = vt[i].w1; m1_address = vt[i].a1;
            m1_byteenable = vt[i].b1; m1_writedata = vt[i].d1;
            #1;
            $display("vec %0d: w0=%b w1=%b cs=%b we=%b addr=%h rdv0=%b rd0=%h rdv1=%b rd1=%h", i,
                     m0_waitrequest, m1_waitrequest, mem_chipselect, mem_write, mem_address,
                     m0_readdatavalid, m0_readdata, m1_readdatavalid, m1_readdata);
            chk($sformatf("v%0d_w0", i), 32'(m0_waitrequest), 32'(vt[i].ew0));
            chk($sformatf("v%0d_w1", i), 32'(m1_waitrequest), 32'(vt[i].ew1));
            chk($sformatf("v%0d_cs", i), 32'(mem_chipselect), 32'(vt[i].ecs));
            chk($sformatf("v%0d_we", i), 32'(mem_write), 32'(vt[i].ewe));
            chk($sformatf("v%0d_addr", i), 32'(mem_address), 32'(vt[i].eaddr));
            chk($sformatf("v%0d_rdv0", i), 32'(m0_readdatavalid), 32'(vt[i].ev0));
            chk($sformatf("v%0d_rd0", i), 32'(m0_readdata), 32'(vt[i].erd0));
            chk($sformatf("v%0d_rdv1", i), 32'(m1_readdatavalid), 32'(vt[i].ev1));
            chk($sformatf("v%0d_rd1", i), 32'(m1_readdata), 32'(vt[i].erd1));
        end
        idle_inputs();
        @(negedge clk);
        $display("oor write: ram[15360]=%h", ram[15360]);
        chk("oor_write_dropped", 32'(ram[15360]), 32'h0F0F);

        // streaming: m0 writes, m1 reads back, both from a fresh reset
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        wi = 0; ri = 0; rcount = 0; m0_rdv_seen = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            m0_write = (wi < 4); m0_address = 14'(16'h100 + wi); m0_writedata = 16'(16'h5000 + wi);
            m1_read = (ri < 4); m1_address = 14'(16'h100 + ri);
            #1;
            $display("stream %0d: w0=%b w1=%b rdv1=%b rd1=%h", c, m0_waitrequest, m1_waitrequest,
                     m1_readdatavalid, m1_readdata);
            if (c < 8) begin
                chk($sformatf("stream%0d_w0", c), 32'(m0_waitrequest), 32'(c % 2));
                chk($sformatf("stream%0d_w1", c), 32'(m1_waitrequest), 32'((c + 1) % 2));
            end
            if (m1_readdatavalid) begin
                chk($sformatf("stream_rd%0d", rcount), 32'(m1_readdata), 32'h5000 + 32'(rcount));
                rcount++;
            end
            if (m0_readdatavalid) m0_rdv_seen++;
            if (!m0_waitrequest) wi++;
            if (!m1_waitrequest) ri++;
        end
        chk("stream_writes", 32'(wi), 4);
        chk("stream_reads", 32'(ri), 4);
        chk("stream_results", 32'(rcount), 4);
        chk("stream_no_m0_rdv", 32'(m0_rdv_seen), 0);
        idle_inputs();

        // clear while m0 waits for a read of word 0
        @(negedge clk);
        m0_read = 1'b1; m0_address = 14'd0; clear_req = 1'b1;
        #1;
        $display("clear start: w0=%b cs=%b", m0_waitrequest, mem_chipselect);
        chk("clr_req_w0", 32'(m0_waitrequest), 1);
        chk("clr_req_cs", 32'(mem_chipselect), 0);
        stall = 1; last_clr = '0; found = 1'b0;
        for (int c = 0; c < DEPTH + 20; c++) begin
            @(negedge clk);
            clear_req = 1'b0;
            #1;
            if (c == 0) begin
                chk("clr_first_ctl", {28'b0, clear_busy, mem_chipselect, mem_write, m1_waitrequest}, 32'hF);
                chk("clr_first_addr", 32'(mem_address), 0);
                chk("clr_first_data", {14'b0, mem_byteenable, mem_writedata}, 32'h30000);
            end
            if (!m0_waitrequest) begin
                found = 1'b1;
                break;
            end
            if (clear_done) chk("clr_done_early", 32'(clear_done), 0);
            if (clear_busy) last_clr = mem_address;
            stall++;
        end
        $display("clear end: stall=%0d last=%0d done=%b", stall, last_clr, clear_done);
        chk("clr_finished", 32'(found), 1);
        chk("clr_stall", 32'(stall), 32'(DEPTH + 1));
        chk("clr_last_addr", 32'(last_clr), 32'(DEPTH - 1));
        chk("clr_done_pulse", 32'(clear_done), 1);
        chk("clr_busy_end", 32'(clear_busy), 0);
        @(negedge clk);
        m0_address = 14'd7000;
        #1;
        $display("post clear rd0: rdv=%b data=%h", m0_readdatavalid, m0_readdata);
        chk("clr_done_one_cycle", 32'(clear_done), 0);
        chk("clr_rd0", {15'b0, m0_readdatavalid, m0_readdata}, 32'h10000);
        @(negedge clk);
        m0_address = 14'd15359;
        #1;
        $display("post clear rd7000: rdv=%b data=%h", m0_readdatavalid, m0_readdata);
        chk("clr_rd7000", {15'b0, m0_readdatavalid, m0_readdata}, 32'h10000);
        @(negedge clk);
        idle_inputs();
        #1;
        $display("post clear rd15359: rdv=%b data=%h", m0_readdatavalid, m0_readdata);
        chk("clr_rd15359", {15'b0, m0_readdatavalid, m0_readdata}, 32'h10000);

        // reset in the middle of a clear
        preload(14'd50, 16'h5555);
        preload(14'd200, 16'hA5A5);
        @(negedge clk);
        clear_req = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            clear_req = 1'b0;
            #1;
            if (clear_busy && mem_address == 14'd100) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reached_100", 32'(found), 1);
        m0_read = 1'b1; m0_address = 14'd3;
        reset_n = 1'b0;
        #1;
        $display("abort: busy=%b cs=%b we=%b w0=%b", clear_busy, mem_chipselect, mem_write, m0_waitrequest);
        chk("abort_outputs", {28'b0, clear_busy, mem_chipselect, mem_write, clear_done}, 0);
        chk("abort_wait", {30'b0, m0_waitrequest, m1_waitrequest}, 3);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        $display("after abort: busy=%b w0=%b ram50=%h ram200=%h", clear_busy, m0_waitrequest, ram[50], ram[200]);
        chk("abort_run_busy", 32'(clear_busy), 0);
        chk("abort_run_grant", 32'(m0_waitrequest), 0);
        chk("abort_word50", 32'(ram[50]), 0);
        chk("abort_word200", 32'(ram[200]), 32'hA5A5);
        idle_inputs();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
